spi_sram_seq: RTL and testbench
===============================

Name: spi_sram_seq

Overview:
- SPI slave sequencer that turns an SPI frame into single-cycle SRAM read/write strokes.
- Sits between the SPI pins and the SRAM macro.
- Shifts in the command byte and address, collects or serves data bytes, and drives the SRAM write-enable, read-enable, address and data lines.
- Replaces the distributed per-field counters and strobes with one FSM that owns all bit counting.

Parameters:
- ADDR_W, 8, address width in bits. Equals the number of address bits shifted in after the command.
- CMD_WRITE, 8'h02, command code for a write.
- CMD_READ, 8'h03, command code for a read.

Ports:
- sck  in  1  SPI clock. All state changes on the rising edge.
- rst  in  1  asynchronous active-high reset.
- ss_n  in  1  active-low slave select, sampled on rising sck.
- sdi  in  1  serial data in, MSB first. Sampled only at edges where ss_n=0.
- sram_rdata  in  8  SRAM read data. Combinationally valid while sram_re=1.
- sdo  out  1  serial data out, MSB first. Equals tx_sr[7].
- sdo_oe  out  1  high only in RDATA.
- sram_addr  out  ADDR_W  SRAM address, registered.
- sram_wdata  out  8  SRAM write data, registered.
- sram_we  out  1  one-cycle write strobe.
- sram_re  out  1  one-cycle read strobe.
- busy  out  1  high whenever state != IDLE.
- cmd_err  out  1  one-cycle pulse when an unknown command is decoded.

Behaviour:
- Reset: all outputs, state, bit counter, shift registers and addr are cleared to 0. State is IDLE.
- Bit counter is 3 bits for byte phases. Address phase counts 0..ADDR_W-1. The counter clears on every phase change.
- Any edge with ss_n=1 forces state to IDLE and clears the bit counter.
  - Any partial byte is discarded; no sram_we is issued for it.
  - An sram_we or sram_re pulse already registered still completes its single cycle.
- IDLE -> CMD on the first edge with ss_n=0. That edge samples command bit 7.
- CMD: 8 bits shifted into cmd_sr. On the edge sampling the 8th bit:
  - value == CMD_WRITE -> ADDR with mode=W.
  - value == CMD_READ -> ADDR with mode=R.
  - any other value -> IGNORE, and cmd_err pulses for 1 cycle.
- ADDR: ADDR_W bits shifted into addr, MSB first. On the last bit:
  - mode=W -> WDATA.
  - mode=R -> RTURN.
- WDATA: 8 bits shifted into rx_sr. On the edge sampling the 8th bit:
  - sram_wdata <= completed byte.
  - sram_we <= 1 for exactly the next cycle, with sram_addr stable during that cycle.
  - Next state: see the BURST_EN feature.
- RTURN: exactly 1 sck cycle (one dummy bit on the bus; sdi ignored).
  - sram_re=1 during this cycle.
  - At the closing edge: tx_sr <= sram_rdata, state -> RDATA.
- RDATA: 8 cycles, sdo_oe=1.
  - sdo = tx_sr[7]; tx_sr shifts left by 1 each edge.
  - After the 8th bit: see the BURST_EN feature.
- IGNORE: holds until ss_n=1. No SRAM strobes, sdo_oe=0.
- DONE: holds until ss_n=1. No SRAM strobes, sdo_oe=0.
- sram_we and sram_re are never high in the same cycle.
- sdo=0 whenever sdo_oe=0.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. The next frame needs ss_n to go low again, i.e. to be seen low at an edge after reset release.

Optional Feature:
- Macro: SPI_SRAM_SEQ_BURST_EN.
- Defined:
  - After each write byte, addr increments by 1 (modulo 2^ADDR_W, so all-ones wraps to 0) in the same cycle sram_we is high. sram_addr shows the pre-increment value for that strobe. State stays in WDATA.
  - After the 8th RDATA bit, addr increments by 1 (same wrap) and state returns to RTURN. Each further read byte therefore costs 1 dummy cycle plus 8 data cycles.
- Undefined:
  - After one data byte (write or read), state goes to DONE.
  - Address never increments.

Test Plan:
- Write: ss_n low, shift 0x02, addr 0x5A, data 0xC3. Expect:
  - sram_we high for exactly 1 cycle, 1 cycle after the 24th bit.
  - sram_addr=0x5A, sram_wdata=0xC3 during the pulse.
  - busy=1 until ss_n=1.
- Read: preload SRAM[0x5A]=0xC3, shift 0x03, addr 0x5A. Expect:
  - sram_re high for 1 cycle with sram_addr=0x5A.
  - Then sdo sequence 1,1,0,0,0,0,1,1 with sdo_oe=1 for exactly 8 cycles.
- Bad command 0x9F: expect cmd_err pulses once, no sram_we/sram_re, sdo_oe=0, and state returns to IDLE after ss_n=1.
- Abort: ss_n raised after 5 of 8 write-data bits. Expect no sram_we, busy=0 on the next edge, and a following full write frame works normally.
- Burst (SPI_SRAM_SEQ_BURST_EN defined), addr 0xFF, data 0x11,0x22. Expect:
  - writes at 0xFF then 0x00 (wrap).
  - without the macro: only 0xFF is written, the second byte is ignored, state is DONE.
- Reset asserted during RDATA bit 3: expect all outputs 0 immediately; after release, with ss_n low at the next edge, the FSM enters CMD.

Source files
------------

// File: rtl/spi_sram_seq.sv
// rtl/spi_sram_seq.sv - SPI slave sequencer turning SPI frames into single-cycle SRAM read/write strokes
// Define SPI_SRAM_SEQ_BURST_EN for auto-incrementing multi-byte bursts.
module spi_sram_seq #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  CMD_WRITE = 8'h02,
    parameter logic [7:0]  CMD_READ  = 8'h03
) (
    input  logic              sck,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              sdi,
    input  logic [7:0]        sram_rdata,
    output logic              sdo,
    output logic              sdo_oe,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_wdata,
    output logic              sram_we,
    output logic              sram_re,
    output logic              busy,
    output logic              cmd_err
);
    localparam int CNT_W = (ADDR_W > 8) ? $clog2(ADDR_W) : 3;
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RTURN, RDATA, IGNORE, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [6:0]        cmd_q, cmd_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mode_w_q, mode_w_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [7:0]        sram_wdata_q, sram_wdata_d;
    logic              we_q, we_d, re_q, re_d, err_q, err_d;
    logic [7:0]        cmd_next, rx_next;
    logic [ADDR_W-1:0] addr_next;

    // Shift views include the bit arriving on this edge, so the last bit is decoded without a stall.
    assign cmd_next  = {cmd_q, sdi};
    assign rx_next   = {rx_q, sdi};
    assign addr_next = {addr_q[ADDR_W-2:0], sdi};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        cmd_d        = cmd_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        addr_d       = addr_q;
        mode_w_d     = mode_w_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        we_d         = 1'b0;
        re_d         = 1'b0;
        err_d        = 1'b0;
        if (ss_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_d   = cmd_next[6:0];
                    cnt_d   = CNT_W'(1);
                    state_d = CMD;
                end
                CMD: begin
                    cmd_d = cmd_next[6:0];
                    if (cnt_q == BYTE_LAST) begin
                        cnt_d = '0;
                        if (cmd_next == CMD_WRITE) begin
                            state_d  = ADDR;
                            mode_w_d = 1'b1;
                        end else if (cmd_next == CMD_READ) begin
                            state_d  = ADDR;
                            mode_w_d = 1'b0;
                        end else begin
                            state_d = IGNORE;
                            err_d   = 1'b1;
                        end
                    end
                end
                ADDR: begin
                    addr_d = addr_next;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d = '0;
                        if (mode_w_q) begin
                            state_d = WDATA;
                        end else begin
                            state_d     = RTURN;
                            re_d        = 1'b1;
                            sram_addr_d = addr_next;
                        end
                    end
                end
                WDATA: begin
                    rx_d = rx_next[6:0];
                    if (cnt_q == BYTE_LAST) begin
                        cnt_d        = '0;
                        we_d         = 1'b1;
                        sram_wdata_d = rx_next;
                        sram_addr_d  = addr_q;
`ifdef SPI_SRAM_SEQ_BURST_EN
                        addr_d       = addr_q + ADDR_W'(1);
`else
                        state_d      = DONE;
`endif
                    end
                end
                RTURN: begin
                    tx_d    = sram_rdata;
                    cnt_d   = '0;
                    state_d = RDATA;
                end
                RDATA: begin
                    tx_d = {tx_q[6:0], 1'b0};
                    if (cnt_q == BYTE_LAST) begin
                        cnt_d       = '0;
`ifdef SPI_SRAM_SEQ_BURST_EN
                        // Next read stroke already points at the incremented address.
                        addr_d      = addr_q + ADDR_W'(1);
                        sram_addr_d = addr_q + ADDR_W'(1);
                        re_d        = 1'b1;
                        state_d     = RTURN;
`else
                        state_d     = DONE;
`endif
                    end
                end
                IGNORE, DONE: cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cmd_q        <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            addr_q       <= '0;
            mode_w_q     <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            mode_w_q     <= mode_w_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            we_q         <= we_d;
            re_q         <= re_d;
            err_q        <= err_d;
        end
    end

    assign sdo_oe     = (state_q == RDATA);
    assign sdo        = sdo_oe & tx_q[7];
    assign busy       = (state_q != IDLE);
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_we    = we_q;
    assign sram_re    = re_q;
    assign cmd_err    = err_q;
endmodule

// File: tb/tb_spi_sram_seq.sv
// tb/tb_spi_sram_seq.sv - self-checking bench for spi_sram_seq: vector table, corner sequences, random frames vs frame model
module tb_spi_sram_seq;
    localparam logic [7:0] W = 8'h02;
    localparam logic [7:0] R = 8'h03;
`ifdef SPI_SRAM_SEQ_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic sck = 1'b0, rst = 1'b0, ss_n = 1'b1, sdi = 1'b0;
    logic [7:0] sram_rdata, sram_addr, sram_wdata;
    logic sdo, sdo_oe, sram_we, sram_re, busy, cmd_err;

    logic [7:0] sram [256];
    logic [7:0] ref_mem [256];
    int checks = 0, errors = 0;

    typedef struct {int idx; logic [7:0] a; logic [7:0] d;} stroke_t;
    stroke_t obs_w[$], obs_r[$], exp_w[$], exp_r[$];
    logic obs_sdo[$], exp_sdo[$];
    int obs_err, obs_bad, obs_idle_busy, obs_oe_first, exp_err;
    logic end_busy;

    typedef struct {
        logic [7:0] cmd; logic [7:0] addr; logic [31:0] data; int nbits;
        int nw; logic [7:0] wa; logic [7:0] wd; int nr; logic [7:0] ra; int noe; logic [7:0] rbyte; int err;
    } vec_t;
    vec_t vecs [8];

    spi_sram_seq dut (
        .sck(sck), .rst(rst), .ss_n(ss_n), .sdi(sdi), .sram_rdata(sram_rdata),
        .sdo(sdo), .sdo_oe(sdo_oe), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_we(sram_we), .sram_re(sram_re), .busy(busy), .cmd_err(cmd_err)
    );

    assign sram_rdata = sram_re ? sram[sram_addr] : 8'h00;
    always #5 sck = ~sck;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_obs();
        obs_w.delete(); obs_r.delete(); obs_sdo.delete();
        obs_err = 0; obs_bad = 0; obs_idle_busy = 0; obs_oe_first = -1;
    endtask

    // One sck period: drive at the falling edge, sample after the next falling edge.
    task automatic tick(input logic s, input logic b, input int idx);
        stroke_t st;
        ss_n = s;
        sdi  = b;
        @(posedge sck);
        @(negedge sck);
        if (sram_we) begin
            st.idx = idx; st.a = sram_addr; st.d = sram_wdata;
            obs_w.push_back(st);
            sram[sram_addr] = sram_wdata;
        end
        if (sram_re) begin
            st.idx = idx; st.a = sram_addr; st.d = 8'h00;
            obs_r.push_back(st);
        end
        if (sdo_oe) begin
            if (obs_oe_first < 0) obs_oe_first = idx;
            obs_sdo.push_back(sdo);
        end
        if (cmd_err) obs_err++;
        if ((sram_we && sram_re) || (!sdo_oe && sdo)) obs_bad++;
        if (!s && !busy) obs_idle_busy++;
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] data, input int nbits);
        logic [47:0] stream;
        stream = {cmd, addr, data};
        clear_obs();
        for (int i = 0; i < nbits; i++) tick(1'b0, (i < 48) ? stream[47-i] : 1'b0, i);
        tick(1'b1, 1'b0, nbits);
        end_busy = busy;
        tick(1'b1, 1'b0, nbits + 1);
    endtask

    // Frame-level reference: which strokes and read bits a frame of nbits selected bits must produce.
    task automatic model_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] data, input int nbits);
        stroke_t st;
        logic [7:0] a;
        exp_w.delete(); exp_r.delete(); exp_sdo.delete();
        exp_err = (nbits >= 8 && cmd != W && cmd != R) ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0 && !BURST) break;
            a = addr + 8'(k);
            if (cmd == W && nbits >= 24 + 8*k) begin
                st.idx = 23 + 8*k; st.a = a; st.d = data[31-8*k -: 8];
                exp_w.push_back(st);
                ref_mem[a] = st.d;
            end
            if (cmd == R && nbits >= 16 + 9*k) begin
                st.idx = 15 + 9*k; st.a = a; st.d = 8'h00;
                exp_r.push_back(st);
                for (int i = 0; i < 8; i++)
                    if (16 + 9*k + i < nbits) exp_sdo.push_back(ref_mem[a][7-i]);
            end
        end
    endtask

    task automatic check_model(input string nm);
        chk({nm, " write count"}, 32'(obs_w.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            chk({nm, " write cycle"}, 32'(obs_w[i].idx), 32'(exp_w[i].idx));
            chk({nm, " write addr"}, 32'(obs_w[i].a), 32'(exp_w[i].a));
            chk({nm, " write data"}, 32'(obs_w[i].d), 32'(exp_w[i].d));
        end
        chk({nm, " read count"}, 32'(obs_r.size()), 32'(exp_r.size()));
        for (int i = 0; i < exp_r.size() && i < obs_r.size(); i++) begin
            chk({nm, " read cycle"}, 32'(obs_r[i].idx), 32'(exp_r[i].idx));
            chk({nm, " read addr"}, 32'(obs_r[i].a), 32'(exp_r[i].a));
        end
        chk({nm, " sdo bit count"}, 32'(obs_sdo.size()), 32'(exp_sdo.size()));
        for (int i = 0; i < exp_sdo.size() && i < obs_sdo.size(); i++)
            chk({nm, " sdo bit"}, 32'(obs_sdo[i]), 32'(exp_sdo[i]));
        chk({nm, " cmd_err pulses"}, 32'(obs_err), 32'(exp_err));
        chk({nm, " strobe/sdo invariants"}, 32'(obs_bad), 32'd0);
        chk({nm, " busy while selected"}, 32'(obs_idle_busy), 32'd0);
        chk({nm, " busy after deselect"}, 32'(end_busy), 32'd0);
    endtask

    function automatic logic [21:0] all_outs();
        return {sdo, sdo_oe, sram_addr, sram_wdata, sram_we, sram_re, busy, cmd_err};
    endfunction

    initial begin
        logic [7:0] cmd, addr, rb;
        logic [31:0] data;
        logic [47:0] stream;
        int nbits, sel;

        for (int i = 0; i < 256; i++) begin
            sram[i] = 8'(i) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'hA5;
        end
        sram[8'h5A] = 8'hC3;
        ref_mem[8'h5A] = 8'hC3;

        vecs[0] = '{W,     8'h5A, 32'hC300_0000, 24, 1, 8'h5A, 8'hC3, 0, 8'h00, 0, 8'h00, 0};
        vecs[1] = '{R,     8'h5A, 32'h0000_0000, 24, 0, 8'h00, 8'h00, 1, 8'h5A, 8, 8'hC3, 0};
        vecs[2] = '{8'h9F, 8'h5A, 32'hC300_0000, 24, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 1};
        vecs[3] = '{W,     8'h5A, 32'hFF00_0000, 21, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0};
        vecs[4] = '{W,     8'h00, 32'h3C00_0000, 24, 1, 8'h00, 8'h3C, 0, 8'h00, 0, 8'h00, 0};
        vecs[5] = '{R,     8'hFF, 32'h0000_0000, 24, 0, 8'h00, 8'h00, 1, 8'hFF, 8, 8'h5A, 0};
        vecs[6] = '{W,     8'h5A, 32'h1234_5678,  5, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0};
        vecs[7] = '{8'h01, 8'h5A, 32'h0000_0000,  8, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 1};

        #1 rst = 1'b1;
        #2 chk("reset outputs", 32'(all_outs()), 32'd0);
        @(negedge sck);
        rst = 1'b0;
        tick(1'b1, 1'b0, 0);
        chk("idle after reset release", 32'(all_outs()), 32'd0);

        for (int v = 0; v < 8; v++) begin
            model_frame(vecs[v].cmd, vecs[v].addr, vecs[v].data, vecs[v].nbits);
            run_frame(vecs[v].cmd, vecs[v].addr, vecs[v].data, vecs[v].nbits);
            chk($sformatf("vec%0d write count", v), 32'(obs_w.size()), 32'(vecs[v].nw));
            if (vecs[v].nw > 0 && obs_w.size() > 0) begin
                chk($sformatf("vec%0d write addr", v), 32'(obs_w[0].a), 32'(vecs[v].wa));
                chk($sformatf("vec%0d write data", v), 32'(obs_w[0].d), 32'(vecs[v].wd));
            end
            chk($sformatf("vec%0d read count", v), 32'(obs_r.size()), 32'(vecs[v].nr));
            if (vecs[v].nr > 0 && obs_r.size() > 0)
                chk($sformatf("vec%0d read addr", v), 32'(obs_r[0].a), 32'(vecs[v].ra));
            chk($sformatf("vec%0d sdo_oe cycles", v), 32'(obs_sdo.size()), 32'(vecs[v].noe));
            if (vecs[v].noe == 8 && obs_sdo.size() == 8) begin
                for (int i = 0; i < 8; i++) rb[7-i] = obs_sdo[i];
                chk($sformatf("vec%0d read byte", v), 32'(rb), 32'(vecs[v].rbyte));
            end
            chk($sformatf("vec%0d cmd_err", v), 32'(obs_err), 32'(vecs[v].err));
            chk($sformatf("vec%0d invariants", v), 32'(obs_bad), 32'd0);
            chk($sformatf("vec%0d busy after deselect", v), 32'(end_busy), 32'd0);
        end

        model_frame(W, 8'h5A, 32'hC300_0000, 24);
        run_frame(W, 8'h5A, 32'hC300_0000, 24);
        check_model("write timing");
        if (obs_w.size() > 0) chk("write strobe after 24th bit", 32'(obs_w[0].idx), 32'd23);

        model_frame(R, 8'h5A, 32'h0, 24);
        run_frame(R, 8'h5A, 32'h0, 24);
        check_model("read timing");
        chk("first sdo_oe cycle", 32'(obs_oe_first), 32'd16);

        model_frame(W, 8'hFF, 32'h1122_0000, 32);
        run_frame(W, 8'hFF, 32'h1122_0000, 32);
        check_model("burst wrap");
        chk("burst wrap write count", 32'(obs_w.size()), BURST ? 32'd2 : 32'd1);
        if (BURST && obs_w.size() > 1) begin
            chk("burst wrap 2nd addr", 32'(obs_w[1].a), 32'h00);
            chk("burst wrap 2nd data", 32'(obs_w[1].d), 32'h22);
        end

        stream = {R, 8'h5A, 32'h0};
        clear_obs();
        for (int i = 0; i < 20; i++) tick(1'b0, stream[47-i], i);
        chk("pre-reset sdo_oe", 32'(sdo_oe), 32'd1);
        chk("pre-reset sdo bits", 32'(obs_sdo.size()), 32'd4);
        if (obs_sdo.size() == 4)
            chk("pre-reset sdo value", 32'({obs_sdo[0], obs_sdo[1], obs_sdo[2], obs_sdo[3]}), 32'hC);
        rst = 1'b1;
        #1 chk("reset mid-RDATA outputs", 32'(all_outs()), 32'd0);
        @(negedge sck);
        rst = 1'b0;
        model_frame(W, 8'h33, 32'h7700_0000, 24);
        run_frame(W, 8'h33, 32'h7700_0000, 24);
        check_model("post-reset write");

        for (int t = 0; t < 40; t++) begin
            sel  = $urandom_range(0, 3);
            cmd  = (sel < 2) ? W : (sel == 2) ? R : 8'($urandom);
            addr = 8'($urandom);
            data = $urandom;
            if ($urandom_range(0, 1) == 1)
                nbits = (cmd == R) ? 16 + 9 * $urandom_range(0, 3) : 16 + 8 * $urandom_range(0, 4);
            else
                nbits = (cmd == R) ? $urandom_range(0, 43) : $urandom_range(0, 48);
            model_frame(cmd, addr, data, nbits);
            run_frame(cmd, addr, data, nbits);
            check_model($sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
